// File: rtl/maze_pkg.sv
// Shared maze constants and helpers used by the maze display scanner and the cell writer.
//   MAZE_X_SIZE / MAZE_Y_SIZE : maze extent in cells
//   MAZE_BOX_SIZE             : cell edge length in pixels
//   MAZE_ROW_STRIDE           : RAM words per maze row (rows are padded to 16)
//   CELL_W / cell_t           : width and type of one stored cell value
//   cell_addr(x, y)           : RAM address of cell (x, y)
package maze_pkg;

  localparam int unsigned MAZE_X_SIZE     = 8;
  localparam int unsigned MAZE_Y_SIZE     = 6;
  localparam int unsigned MAZE_BOX_SIZE   = 20;
  localparam int unsigned MAZE_ROW_STRIDE = 16;
  localparam int unsigned CELL_W          = 3;

  typedef logic [CELL_W-1:0] cell_t;

  // Quotients of 8-bit pixels by the box size stay below 16, so the result fits in 8 bits.
  function automatic logic [7:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
    return 8'(x) + 8'(y) * 8'(MAZE_ROW_STRIDE);
  endfunction

endpackage

// File: rtl/pix_to_cell_div.sv
// Per-axis pixel-to-cell converter using repeated subtraction of BOX_SIZE.
//   clk, resetn : clock and synchronous active-low reset
//   start       : load pix as the new remainder and clear the quotient
//   pix         : pixel coordinate sampled on start
//   quot        : cell index accumulated so far
//   done        : remainder is below BOX_SIZE, so quot is final
module pix_to_cell_div
  import maze_pkg::*;
#(
  parameter int unsigned BOX_SIZE = MAZE_BOX_SIZE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] pix,
  output logic [3:0] quot,
  output logic       done
);

  localparam logic [7:0] Box = 8'(BOX_SIZE);

  logic [7:0] rem_q, rem_d;
  logic [3:0] quot_q, quot_d;

  // Subtraction is free-running; once the remainder drops below Box it stops on its own.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    if (start) begin
      rem_d  = pix;
      quot_d = '0;
    end else if (rem_q >= Box) begin
      rem_d  = rem_q - Box;
      quot_d = quot_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot = quot_q;
  assign done = (rem_q < Box);

endmodule

// File: rtl/maze_cell_writer.sv
// Converts a pixel location into a maze cell and writes a value into the maze RAM.
//   clk, resetn          : clock and synchronous active-low reset
//   req_valid/req_ready  : write request handshake (ready only while idle)
//   x_pix, y_pix, wr_val : target pixel and value, sampled on accept
//   address, data, wren  : RAM write port; address/data hold between writes
//   done                 : one-cycle pulse when a write or a clear completes
//   err                  : one-cycle pulse when the target lies outside the maze
//   clear_start          : start a bulk clear (MAZE_WR_CLEAR_EN only)
//   clear_busy           : bulk clear sweep in progress (MAZE_WR_CLEAR_EN only)
// Optional feature macro: MAZE_WR_CLEAR_EN enables the bulk clear sweep writing CLEAR_VAL.
module maze_cell_writer
  import maze_pkg::*;
#(
  parameter int unsigned X_SIZE   = MAZE_X_SIZE,
  parameter int unsigned Y_SIZE   = MAZE_Y_SIZE,
  parameter int unsigned BOX_SIZE = MAZE_BOX_SIZE,
  parameter int unsigned DATA_W   = CELL_W
`ifdef MAZE_WR_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        x_pix,
  input  logic [7:0]        y_pix,
  input  logic [DATA_W-1:0] wr_val,
  output logic [7:0]        address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              done,
  output logic              err
`ifdef MAZE_WR_CLEAR_EN
  ,
  input  logic              clear_start,
  output logic              clear_busy
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StWrite,
    StErr
`ifdef MAZE_WR_CLEAR_EN
    ,
    StClear,
    StClearDone
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] val_q, val_d;

  logic       div_start;
  logic [3:0] qx, qy;
  logic       done_x, done_y;

`ifdef MAZE_WR_CLEAR_EN
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
`endif

  pix_to_cell_div #(
    .BOX_SIZE (BOX_SIZE)
  ) u_div_x (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .pix    (x_pix),
    .quot   (qx),
    .done   (done_x)
  );

  pix_to_cell_div #(
    .BOX_SIZE (BOX_SIZE)
  ) u_div_y (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .pix    (y_pix),
    .quot   (qy),
    .done   (done_y)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    val_d     = val_q;
    div_start = 1'b0;
    req_ready = 1'b0;
    wren      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
`ifdef MAZE_WR_CLEAR_EN
    cx_d       = cx_q;
    cy_d       = cy_q;
    clear_busy = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
`ifdef MAZE_WR_CLEAR_EN
        // A clear takes priority; the request stays pending until the sweep ends.
        if (clear_start) begin
          state_d = StClear;
          cx_d    = '0;
          cy_d    = '0;
          addr_d  = cell_addr(4'd0, 4'd0);
          data_d  = CLEAR_VAL;
        end else
`endif
        if (req_valid) begin
          div_start = 1'b1;
          val_d     = wr_val;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (done_x && done_y) begin
          if ((32'(qx) < X_SIZE) && (32'(qy) < Y_SIZE)) begin
            state_d = StWrite;
            addr_d  = cell_addr(qx, qy);
            data_d  = val_q;
          end else begin
            state_d = StErr;
          end
        end
      end
      StWrite: begin
        wren    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err     = 1'b1;
        state_d = StIdle;
      end
`ifdef MAZE_WR_CLEAR_EN
      StClear: begin
        wren       = 1'b1;
        clear_busy = 1'b1;
        if (cx_q == 4'(X_SIZE - 1)) begin
          if (cy_q == 4'(Y_SIZE - 1)) begin
            // Last cell: leave address on it so it holds after the sweep.
            state_d = StClearDone;
          end else begin
            cx_d   = '0;
            cy_d   = cy_q + 4'd1;
            addr_d = cell_addr(4'd0, cy_q + 4'd1);
          end
        end else begin
          cx_d   = cx_q + 4'd1;
          addr_d = cell_addr(cx_q + 4'd1, cy_q);
        end
      end
      StClearDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      val_q   <= '0;
`ifdef MAZE_WR_CLEAR_EN
      cx_q    <= '0;
      cy_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      val_q   <= val_d;
`ifdef MAZE_WR_CLEAR_EN
      cx_q    <= cx_d;
      cy_q    <= cy_d;
`endif
    end
  end

  assign address = addr_q;
  assign data    = data_q;

endmodule

// File: tb/tb_maze_cell_writer.sv
// Self-checking bench for maze_cell_writer: a cycle-level reference model derived from the
// pixel/cell arithmetic, a per-cycle compare process, and directed requests with literal
// expectations for latency, address and data.
module tb_maze_cell_writer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] x_pix = '0;
  logic [7:0] y_pix = '0;
  logic [2:0] wr_val = '0;
  logic [7:0] address;
  logic [2:0] data;
  logic       wren, done, err;
  logic       clr_in = 1'b0;
`ifdef MAZE_WR_CLEAR_EN
  logic       clear_busy;
`endif

  int n_checks = 0;
  int n_err = 0;

  maze_cell_writer dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .x_pix       (x_pix),
    .y_pix       (y_pix),
    .wr_val      (wr_val),
    .address     (address),
    .data        (data),
    .wren        (wren),
    .done        (done),
    .err         (err)
`ifdef MAZE_WR_CLEAR_EN
    ,
    .clear_start (clr_in),
    .clear_busy  (clear_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many cycles remain in the current operation.
  bit   m_live = 0, m_busy = 0, m_clear = 0, m_inb = 0, was_idle;
  int   m_left = 0, m_qx = 0, m_qy = 0, m_idx;
  int   m_val = 0;
  bit   e_ready = 0, e_wren = 0, e_done = 0, e_err = 0, e_cbusy = 0;
  int   e_addr = 0, e_data = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_live = 1; m_busy = 0; m_clear = 0; m_left = 0;
      e_wren = 0; e_done = 0; e_err = 0; e_cbusy = 0; e_addr = 0; e_data = 0;
    end else begin
      was_idle = !m_busy;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      if (was_idle) begin
        if (clr_in) begin
          m_busy = 1; m_clear = 1;
          m_left = 8 * 6 + 1;
        end else if (req_valid) begin
          m_qx   = int'(x_pix) / 20;
          m_qy   = int'(y_pix) / 20;
          m_inb  = (m_qx < 8) && (m_qy < 6);
          m_val  = int'(wr_val);
          m_left = ((m_qx > m_qy) ? m_qx : m_qy) + 2;
          m_busy = 1; m_clear = 0;
        end
      end
      e_wren = 0; e_done = 0; e_err = 0; e_cbusy = 0;
      if (m_busy && m_clear) begin
        if (m_left >= 2) begin
          m_idx  = 49 - m_left;
          e_wren = 1; e_cbusy = 1;
          e_addr = (m_idx % 8) + (m_idx / 8) * 16;
          e_data = 0;
        end else begin
          e_done = 1;
        end
      end else if (m_busy && m_left == 1) begin
        if (m_inb) begin
          e_wren = 1; e_done = 1;
          e_addr = m_qx + m_qy * 16;
          e_data = m_val;
        end else begin
          e_err = 1;
        end
      end
    end
    e_ready = !m_busy;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", int'(req_ready), int'(e_ready));
      chk("wren", int'(wren), int'(e_wren));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("address", int'(address), e_addr);
      chk("data", int'(data), e_data);
`ifdef MAZE_WR_CLEAR_EN
      chk("clear_busy", int'(clear_busy), int'(e_cbusy));
`endif
    end
  end

  // Issue one request and check the outcome cycle, address and data literally.
  task automatic do_req(input logic [7:0] x, input logic [7:0] y, input logic [2:0] v,
                        input int lat, input int addr, input bit is_err);
    int  n;
    bit  hit;
    @(negedge clk); #1;
    req_valid = 1'b1; x_pix = x; y_pix = y; wr_val = v;
    n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; x_pix = 8'($urandom); y_pix = 8'($urandom); wr_val = 3'($urandom);
    n = 0; hit = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      if (wren || err) hit = 1;
    end
    chk("latency", n, lat);
    chk("pulse_err", int'(err), int'(is_err));
    chk("pulse_done", int'(done), int'(!is_err));
    if (!is_err) begin
      chk("req_addr", int'(address), addr);
      chk("req_data", int'(data), int'(v));
    end
  endtask

  initial begin
    int n, gap, cnt, run, first_a, last_a;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_addr", int'(address), 0);
    chk("reset_wren", int'(wren), 0);

    do_req(8'd45, 8'd30, 3'd5, 4, 18, 1'b0);
    @(negedge clk);
    chk("ready_after_write", int'(req_ready), 1);
    do_req(8'd0, 8'd0, 3'd3, 2, 0, 1'b0);
    do_req(8'd159, 8'd119, 3'd6, 9, 87, 1'b0);
    do_req(8'd140, 8'd100, 3'd1, 9, 87, 1'b0);
    do_req(8'd20, 8'd40, 3'd2, 4, 33, 1'b0);
    do_req(8'd160, 8'd10, 3'd2, 10, 0, 1'b1);
    do_req(8'd10, 8'd120, 3'd7, 8, 0, 1'b1);

    // Back-to-back with valid held: writes spaced by latency plus one idle cycle.
    @(negedge clk); #1;
    req_valid = 1'b1; x_pix = 8'd45; y_pix = 8'd30; wr_val = 3'd4;
    n = 0;
    while (!wren && n < 60) begin @(negedge clk); n++; end
    chk("b2b_first_addr", int'(address), 18);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!wren && gap < 60);
    #1 req_valid = 1'b0;
    chk("b2b_gap", gap, 5);
    chk("b2b_second_data", int'(data), 4);

    // Reset in the middle of a long division.
    @(negedge clk); #1;
    req_valid = 1'b1; x_pix = 8'd200; y_pix = 8'd100; wr_val = 3'd6;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    @(negedge clk); #1 resetn = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (wren || err) cnt++;
    end
    chk("reset_abort_pulses", cnt, 0);
    chk("reset_abort_addr", int'(address), 0);
    do_req(8'd45, 8'd30, 3'd5, 4, 18, 1'b0);

`ifdef MAZE_WR_CLEAR_EN
    // Clear collides with a request; the request waits for the sweep.
    @(negedge clk); #1;
    clr_in = 1'b1; req_valid = 1'b1; x_pix = 8'd20; y_pix = 8'd40; wr_val = 3'd7;
    @(posedge clk); #1 clr_in = 1'b0;
    run = 0; first_a = -1; last_a = -1; n = 0;
    while (n < 120) begin
      @(negedge clk);
      n++;
      if (wren) begin
        if (run == 0) first_a = int'(address);
        last_a = int'(address);
        run++;
      end else if (run > 0) begin
        break;
      end
    end
    chk("clear_len", run, 48);
    chk("clear_first", first_a, 0);
    chk("clear_last", last_a, 87);
    chk("clear_done", int'(done), 1);
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!wren && n < 60) begin @(negedge clk); n++; end
    chk("post_clear_lat", n, 4);
    chk("post_clear_addr", int'(address), 33);
    chk("post_clear_data", int'(data), 7);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maze_cell_writer.md
Name: maze_cell_writer

Overview:
- Write-side counterpart to the maze display scanner: converts a pixel-space location into a maze cell and writes a cell value into the maze RAM.
- The RAM uses the same layout as the scanner: address = cellX + cellY*16.
- Sits between game logic (player position, path marking) and the maze RAM write port.
- Pixel-to-cell division is iterative repeated subtraction by BOX_SIZE, so there is no divider.

Parameters:
- X_SIZE, 8, maze width in cells.
- Y_SIZE, 6, maze height in cells.
- BOX_SIZE, 20, cell edge in pixels.
- DATA_W, 3, cell value width.
- CLEAR_VAL, 0, value written by bulk clear (optional feature only).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  block idle, request accepted when valid&&ready.
- x_pix  in  8  pixel x of target.
- y_pix  in  8  pixel y of target.
- wr_val  in  DATA_W  value to store.
- address  out  8  RAM write address.
- data  out  DATA_W  RAM write data.
- wren  out  1  RAM write enable, one cycle per write.
- done  out  1  one-cycle pulse when a request or clear completes.
- err  out  1  one-cycle pulse when a request is out of bounds; no write is issued.
- clear_start  in  1  start bulk clear (only with macro).
- clear_busy  out  1  sweep in progress (only with macro).

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clk. On reset, state=IDLE, address=0, data=0, wren=0, done=0, err=0, clear_busy=0, and all internal remainders and quotients are 0.
- Reset mid-operation aborts the current operation with no partial write; the next cycle is IDLE.
- req_ready = (state==IDLE), combinational. It is 1 in the first cycle after reset is released.
- IDLE: on valid&&ready, latch remX=x_pix, remY=y_pix and wr_val; clear qX=qY=0 (4 bits each); go to DIV.
- DIV: each cycle, each axis independently:
  - if rem>=BOX_SIZE, then rem-=BOX_SIZE and q+=1;
  - remainder compare is 8-bit unsigned.
- DIV exit: when both rem<BOX_SIZE at the start of a cycle:
  - if qX<X_SIZE and qY<Y_SIZE, go to WRITE;
  - otherwise go to ERR.
  - DIV lasts max(qX,qY)+1 cycles.
- WRITE: wren=1, address=qX+qY*16 (8-bit, no overflow for 8-bit pixel inputs), data=latched value, done=1. Next state is IDLE.
- ERR: err=1, wren=0, done=0. Next state is IDLE.
- Latency: wren (or err) is high in cycle max(qX,qY)+2 after the accept edge.
- address and data hold their last values when wren=0.
- Inputs x_pix, y_pix and wr_val are don't-care outside the accept cycle.
- Boundaries:
  - x_pix=BOX_SIZE*k exactly gives qX=k.
  - x_pix=159, y_pix=119 gives cell (7,5), address 87.
  - x_pix=160 gives err.

Optional Feature:
- Macro: MAZE_WR_CLEAR_EN.
- With the macro:
  - clear_start sampled in IDLE moves to CLEAR; clear_start wins over a simultaneous req_valid, which stays un-accepted.
  - CLEAR sweeps cells raster-order x 0..X_SIZE-1 then y 0..Y_SIZE-1, one write per cycle (wren=1, data=CLEAR_VAL), X_SIZE*Y_SIZE cycles in total.
  - clear_busy=1 throughout the sweep. done pulses in the cycle after the last write, then state returns to IDLE.
  - req_ready=0 during CLEAR.
- Without the macro: the clear_start and clear_busy ports and the CLEAR state do not exist.

Decomposition:
- Shared package maze_pkg:
  - constants MAZE_X_SIZE=8, MAZE_Y_SIZE=6, MAZE_BOX_SIZE=20, MAZE_ROW_STRIDE=16, CELL_W=3;
  - typedef cell_t (logic [CELL_W-1:0]);
  - function cell_addr(x,y) returning x + y*MAZE_ROW_STRIDE, shared with the display scanner.
- One natural sub-module: pix_to_cell_div, a per-axis iterative subtract divider with start/done. It is instantiated twice, for x and y.

Test Plan:
- Request x=45, y=30, val=5 → qX=2, qY=1; wren high exactly 4 cycles after accept; address=18, data=5; done coincident; req_ready back to 1 the next cycle.
- Request x=0, y=0 → wren 2 cycles after accept, address=0. Request x=159, y=119 → address=87 after 9 cycles (qX=7, qY=5).
- Request x=160, y=10 → err pulse, no wren, done=0. Request x=10, y=120 → err.
- Back-to-back requests with req_valid held high → second accepted only in the cycle after WRITE; no overlap; both writes are correct.
- resetn low during DIV of x=200, y=100 → no wren or err ever fires; state IDLE; outputs at reset values; next request completes normally.
- (MAZE_WR_CLEAR_EN) clear_start and req_valid together → 48 consecutive wren cycles, addresses 0..7, 16..23, ..., 80..87, data=0, clear_busy high; done follows; the pending request is then accepted.
